// File: rtl/fixed_point_shift_add_multiplier.sv
// Sequential shift-add multiplier: rebuilds the dividend from a fixed-point
// quotient and integer divisor, one multiplier bit per clock.
module fixed_point_shift_add_multiplier #(
    parameter int QW   = 8,
    parameter int FRAC = 4,
    parameter int BW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [QW-1:0]        q_in,
    input  logic [BW-1:0]        b_in,
    output logic                 busy,
    output logic                 done,
    output logic [QW+BW-1:0]     product,
    output logic [QW+BW-FRAC-1:0] int_part,
    output logic                 exact
);

    localparam int PW = QW + BW;
    localparam int CW = (BW > 1) ? $clog2(BW) : 1;
    localparam logic [CW-1:0] CLAST = CW'(BW - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [PW-1:0] mcand;
    logic [BW-1:0] mplier;
    logic [PW-1:0] acc;
    logic [CW-1:0] cnt;

    logic accept;
    logic last;
    logic [PW-1:0] addend;

    assign accept = (state == IDLE) && start;
    assign last   = (cnt == CLAST);
    assign addend = mplier[0] ? (mcand << cnt) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = FIN;
                end
            end
            FIN: begin
                busy     = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Operands are captured only at acceptance, so input changes mid-run are harmless.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (accept) begin
            mcand  <= PW'(q_in);
            mplier <= b_in;
            acc    <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            acc    <= acc + addend;
            mplier <= mplier >> 1;
            cnt    <= last ? cnt : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            exact   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == FIN) begin
                product <= acc;
                exact   <= (acc[FRAC-1:0] == '0);
                done    <= 1'b1;
            end
        end
    end

    assign int_part = product[PW-1:FRAC];

endmodule

// File: tb/tb_fixed_point_shift_add_multiplier.sv
// Directed-vector bench for the shift-add multiplier.
module tb_fixed_point_shift_add_multiplier;

    localparam int QW   = 8;
    localparam int FRAC = 4;
    localparam int BW   = 4;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [QW-1:0]   q_in;
    logic [BW-1:0]   b_in;
    logic            busy;
    logic            done;
    logic [QW+BW-1:0] product;
    logic [QW+BW-FRAC-1:0] int_part;
    logic            exact;

    int total;
    int passed;

    fixed_point_shift_add_multiplier #(
        .QW(QW), .FRAC(FRAC), .BW(BW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .q_in(q_in),
        .b_in(b_in),
        .busy(busy),
        .done(done),
        .product(product),
        .int_part(int_part),
        .exact(exact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic start_op(input logic [QW-1:0] q, input logic [BW-1:0] b);
        @(negedge clk);
        q_in  = q;
        b_in  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 30);
    endtask

    task automatic count_dones(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
    endtask

    task automatic run_op(input string tag, input logic [QW-1:0] q,
                          input logic [BW-1:0] b, input logic [11:0] ep,
                          input logic [7:0] ei, input logic ex);
        int n;
        start_op(q, b);
        check({tag, "_busy"}, busy, 1'b1);
        wait_done(n);
        check({tag, "_lat"}, n, BW + 1);
        check({tag, "_prod"}, product, ep);
        check({tag, "_int"}, int_part, ei);
        check({tag, "_exact"}, exact, ex);
        check({tag, "_busylow"}, busy, 1'b0);
        @(posedge clk);
        #1;
        check({tag, "_donelow"}, done, 1'b0);
        check({tag, "_hold"}, product, ep);
    endtask

    logic [QW-1:0] qs [3];
    logic [BW-1:0] bs [3];
    logic [11:0]   ps [3];

    initial begin
        int n;
        int pulses;
        total  = 0;
        passed = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        q_in   = '0;
        b_in   = '0;
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_prod", product, 12'h000);
        check("rst_exact", exact, 1'b0);
        rst_n = 1'b1;

        // 1. reset in the middle of a run
        start_op(8'h50, 4'd2);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_busy", busy, 1'b0);
        check("t1_prod", product, 12'h000);
        @(negedge clk);
        rst_n = 1'b1;
        count_dones(10, pulses);
        check("t1_nodone", pulses, 0);
        run_op("t1_after", 8'h50, 4'd2, 12'h0A0, 8'd10, 1'b1);

        // 2-4. directed products
        run_op("t2", 8'h50, 4'd2, 12'h0A0, 8'd10, 1'b1);
        run_op("t3a", 8'h10, 4'd3, 12'h030, 8'd3, 1'b1);
        run_op("t3b", 8'h10, 4'd10, 12'h0A0, 8'd10, 1'b1);
        run_op("t4a", 8'h05, 4'd3, 12'h00F, 8'd0, 1'b0);
        run_op("t4b", 8'hFF, 4'hF, 12'hEF1, 8'hEF, 1'b0);

        // 5. zero multiplier, then start while busy
        run_op("t5a", 8'hAB, 4'd0, 12'h000, 8'd0, 1'b1);
        run_op("t5b", 8'h00, 4'd7, 12'h000, 8'd0, 1'b1);
        start_op(8'h20, 4'd3);
        @(negedge clk);
        q_in  = 8'hFF;
        b_in  = 4'hF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        count_dones(12, pulses);
        check("t5_onedone", pulses, 1);
        check("t5_prod", product, 12'h060);

        // 6. start held high, operands change after each acceptance
        qs[0] = 8'h18; bs[0] = 4'd5;  ps[0] = 12'h078;
        qs[1] = 8'h33; bs[1] = 4'd9;  ps[1] = 12'h1CB;
        qs[2] = 8'hC4; bs[2] = 4'd12; ps[2] = 12'h930;
        @(negedge clk);
        q_in  = qs[0];
        b_in  = bs[0];
        start = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) begin
                q_in = qs[i+1];
                b_in = bs[i+1];
            end else begin
                start = 1'b0;
                q_in  = 8'h00;
                b_in  = 4'd0;
            end
            wait_done(n);
            check($sformatf("t6_lat%0d", i), n, BW + 1);
            check($sformatf("t6_prod%0d", i), product, ps[i]);
            if (i < 2) begin
                @(posedge clk);
                #1;
                check($sformatf("t6_busy%0d", i), busy, 1'b1);
            end
        end
        count_dones(10, pulses);
        check("t6_nomore", pulses, 0);
        check("t6_hold", product, ps[2]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
